// File: rtl/mul_pkg.sv
// Shared sizing helpers for the carry-save multiplier: tree depth, stage count
// and pipeline latency derived from operand width and register spacing.
package mul_pkg;

  localparam int DEF_WIDTH = 24;
  localparam int DEF_LPS   = 2;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  // Row count left after applying 'levels' 3:2 levels to 'rows' rows.
  function automatic int rows_after(input int rows, input int levels);
    int n;
    n = rows;
    for (int l = 0; l < levels; l++) begin
      if (n > 2) n = 2 * (n / 3) + (n % 3);
    end
    return n;
  endfunction

  function automatic int num_levels(input int rows);
    int n;
    int lv;
    n  = rows;
    lv = 0;
    while (n > 2) begin
      n  = 2 * (n / 3) + (n % 3);
      lv = lv + 1;
    end
    return lv;
  endfunction

  // WIDTH partial-product rows plus one Baugh-Wooley correction row.
  function automatic int latency(input int width, input int lps);
    return ceil_div(num_levels(width + 1), lps) + 2;
  endfunction

  localparam int PROD_W  = 2 * DEF_WIDTH;
  localparam int LATENCY = latency(DEF_WIDTH, DEF_LPS);

endpackage

// File: rtl/csa_row.sv
// One row of 3:2 compressors; carry is pre-shifted left by one bit and the
// carry out of the top bit is dropped (it cancels modulo 2^N).
module csa_row #(
  parameter int N = 48
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic [N-1:0] c,
  output logic [N-1:0] sum,
  output logic [N-1:0] carry
);

  always_comb begin
    sum   = a ^ b ^ c;
    carry = '0;
    for (int i = 1; i < N; i++) begin
      carry[i] = (a[i-1] & b[i-1]) | (a[i-1] & c[i-1]) | (b[i-1] & c[i-1]);
    end
  end

endmodule

// File: rtl/mul_csa_pipe.sv
// Pipelined WIDTH x WIDTH multiplier: Baugh-Wooley partial products, 3:2 CSA
// tree registered every LEVELS_PER_STAGE levels, final carry-propagate add.
module mul_csa_pipe
  import mul_pkg::*;
#(
  parameter int WIDTH            = DEF_WIDTH,
  parameter int LEVELS_PER_STAGE = DEF_LPS,
  parameter int TAG_W            = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  input  logic [TAG_W-1:0]   in_tag,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_product,
  output logic [TAG_W-1:0]   out_tag
);

  localparam int PW   = 2 * WIDTH;
  localparam int ROWS = WIDTH + 1;
  localparam int NL   = num_levels(ROWS);
  localparam int NS   = ceil_div(NL, LEVELS_PER_STAGE);

  logic             en;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic             sgn_q, sgn_d;
  logic [NS:0]      vld_q, vld_d;
  logic [TAG_W-1:0] tag_q [NS+1];
  logic [TAG_W-1:0] tag_d [NS+1];
  logic             out_valid_q, out_valid_d;
  logic [PW-1:0]    out_product_q, out_product_d;
  logic [TAG_W-1:0] out_tag_q, out_tag_d;
  logic [PW-1:0]    pp [ROWS];
  logic [PW-1:0]    final_sum;

  assign en       = out_ready | ~out_valid_q;
  assign in_ready = en;

  always_comb begin
    a_d   = a_q;
    b_d   = b_q;
    sgn_d = sgn_q;
    vld_d = vld_q;
    tag_d = tag_q;
    if (en) begin
      a_d      = in_a;
      b_d      = in_b;
      sgn_d    = in_signed;
      vld_d    = {vld_q[NS-1:0], in_valid};
      tag_d[0] = in_tag;
      for (int k = 1; k <= NS; k++) tag_d[k] = tag_q[k-1];
    end
  end

  // Signed mode inverts the cross terms with exactly one MSB operand bit and
  // adds 1 at bits WIDTH and 2*WIDTH-1 through the extra correction row.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      pp[i] = '0;
      for (int j = 0; j < WIDTH; j++) begin
        pp[i][i+j] = (a_q[j] & b_q[i]) ^ (sgn_q & ((i == WIDTH-1) != (j == WIDTH-1)));
      end
    end
    pp[WIDTH]          = '0;
    pp[WIDTH][WIDTH]   = sgn_q;
    pp[WIDTH][PW-1]    = sgn_q;
  end

  for (genvar l = 0; l < NL; l++) begin : g_lvl
    localparam int NI = rows_after(ROWS, l);
    localparam int NG = NI / 3;
    localparam int NO = rows_after(ROWS, l + 1);

    logic [PW-1:0] src [NI];
    logic [PW-1:0] dst [NO];

    if (l == 0) begin : g_src
      assign src = pp;
    end else if ((l % LEVELS_PER_STAGE) == 0) begin : g_src
      assign src = g_lvl[l-1].g_reg.rows_q;
    end else begin : g_src
      assign src = g_lvl[l-1].dst;
    end

    for (genvar g = 0; g < NG; g++) begin : g_csa
      csa_row #(.N(PW)) u_csa (
        .a    (src[3*g]),
        .b    (src[3*g+1]),
        .c    (src[3*g+2]),
        .sum  (dst[2*g]),
        .carry(dst[2*g+1])
      );
    end

    for (genvar r = 0; r < NI - 3*NG; r++) begin : g_pass
      assign dst[2*NG+r] = src[3*NG+r];
    end

    if ((((l + 1) % LEVELS_PER_STAGE) == 0) || (l + 1 == NL)) begin : g_reg
      logic [PW-1:0] rows_d [NO];
      logic [PW-1:0] rows_q [NO];

      always_comb begin
        rows_d = dst;
        if (!en) rows_d = rows_q;
      end

      always_ff @(posedge clk) begin
        rows_q <= rows_d;
      end
    end
  end

  assign final_sum = g_lvl[NL-1].g_reg.rows_q[0] + g_lvl[NL-1].g_reg.rows_q[1];

  // Result registers load only on valid slots so bubbles never disturb them.
  always_comb begin
    out_valid_d   = out_valid_q;
    out_product_d = out_product_q;
    out_tag_d     = out_tag_q;
    if (en) begin
      out_valid_d = vld_q[NS];
      if (vld_q[NS]) begin
        out_product_d = final_sum;
        out_tag_d     = tag_q[NS];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q         <= '0;
      out_valid_q   <= 1'b0;
      out_product_q <= '0;
      out_tag_q     <= '0;
    end else begin
      vld_q         <= vld_d;
      out_valid_q   <= out_valid_d;
      out_product_q <= out_product_d;
      out_tag_q     <= out_tag_d;
    end
  end

  always_ff @(posedge clk) begin
    a_q   <= a_d;
    b_q   <= b_d;
    sgn_q <= sgn_d;
    tag_q <= tag_d;
  end

  assign out_valid   = out_valid_q;
  assign out_product = out_product_q;
  assign out_tag     = out_tag_q;

endmodule

// File: tb/tb_mul_csa_pipe.sv
// Directed and streamed checks of mul_csa_pipe at WIDTH=24, plus WIDTH=8
// instances at the two extremes of register spacing.
module tb_mul_csa_pipe;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid, in_ready, in_signed;
  logic [23:0] in_a, in_b;
  logic [3:0]  in_tag;
  logic        out_valid, out_ready;
  logic [47:0] out_product;
  logic [3:0]  out_tag;

  logic        v8, s8, ordy8;
  logic [7:0]  a8, b8;
  logic [3:0]  tag8;
  logic        rdy8_a, vld8_a, rdy8_b, vld8_b;
  logic [15:0] p8_a, p8_b;
  logic [3:0]  t8_a, t8_b;

  always #5 clk = ~clk;

  mul_csa_pipe #(.WIDTH(24), .LEVELS_PER_STAGE(2), .TAG_W(4)) u_dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .in_signed(in_signed), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_product(out_product), .out_tag(out_tag)
  );

  mul_csa_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(1), .TAG_W(4)) u_w8_l1 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8_a),
    .in_a(a8), .in_b(b8), .in_signed(s8), .in_tag(tag8),
    .out_valid(vld8_a), .out_ready(ordy8),
    .out_product(p8_a), .out_tag(t8_a)
  );

  mul_csa_pipe #(.WIDTH(8), .LEVELS_PER_STAGE(4), .TAG_W(4)) u_w8_l4 (
    .clk(clk), .rst(rst), .in_valid(v8), .in_ready(rdy8_b),
    .in_a(a8), .in_b(b8), .in_signed(s8), .in_tag(tag8),
    .out_valid(vld8_b), .out_ready(ordy8),
    .out_product(p8_b), .out_tag(t8_b)
  );

  typedef struct {
    logic [47:0] prod;
    logic [3:0]  tag;
  } exp_t;

  exp_t        sb_q [$];
  int          out_cyc [$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_out = 0;
  int          cyc = 0;
  logic [3:0]  tag_ctr = 4'h0;

  localparam int N8 = 4096;
  logic [15:0] exp8 [N8];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", nm, got, exp);
  endtask

  function automatic logic [63:0] ref_mul(input logic [63:0] a, input logic [63:0] b,
                                          input bit s, input int w);
    longint     sa, sb;
    logic [63:0] m;
    m  = (64'd1 << w) - 64'd1;
    sa = longint'(a & m);
    sb = longint'(b & m);
    if (s) begin
      if (a[w-1]) sa = sa - longint'(64'd1 << w);
      if (b[w-1]) sb = sb - longint'(64'd1 << w);
    end
    m = (64'd1 << (2*w)) - 64'd1;
    return 64'(sa * sb) & m;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor: a transfer happens on the coming edge when valid & ready.
  always @(negedge clk) begin
    exp_t e;
    #2;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("spurious_out", {63'b0, out_valid}, 64'd0);
      end else begin
        e = sb_q.pop_front();
        chk("out_product", out_product, e.prod);
        chk("out_tag", out_tag, e.tag);
        out_cyc.push_back(cyc);
        n_out++;
      end
    end
  end

  task automatic drain(input string nm);
    int t;
    t = 0;
    while (sb_q.size() != 0 && t < 40) begin
      @(negedge clk);
      #3;
      t++;
    end
    chk(nm, sb_q.size(), 0);
    sb_q.delete();
  endtask

  task automatic send_dir(input logic [23:0] a, input logic [23:0] b, input logic s,
                          input logic [3:0] tg, input logic [47:0] exp, input string nm);
    int   cnt;
    exp_t e;
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_a      = a;
    in_b      = b;
    in_signed = s;
    in_tag    = tg;
    e.prod = exp;
    e.tag  = tg;
    sb_q.push_back(e);
    @(posedge clk);
    cnt = 1;
    #1;
    in_valid = 1'b0;
    while (out_valid !== 1'b1 && cnt < 20) begin
      @(posedge clk);
      #1;
      cnt++;
    end
    chk({nm, "_latency"}, cnt, 6);
    drain({nm, "_drain"});
  endtask

  task automatic stream(input int n, input int st_at, input int st_len, output int iters);
    int          sent, k;
    exp_t        e;
    logic [63:0] p;
    sent = 0;
    k    = 0;
    while (sent < n && k < n + st_len + 20) begin
      @(negedge clk);
      out_ready = (k >= st_at && k < st_at + st_len) ? 1'b0 : 1'b1;
      in_valid  = 1'b1;
      in_a      = 24'($urandom);
      in_b      = 24'($urandom);
      in_signed = sent[0];
      in_tag    = tag_ctr;
      #1;
      if (!out_ready) begin
        chk("stall_in_ready", {63'b0, in_ready}, 64'd0);
        chk("stall_out_valid", {63'b0, out_valid}, 64'd1);
        if (sb_q.size() > 0) begin
          chk("stall_product", out_product, sb_q[0].prod);
          chk("stall_tag", out_tag, sb_q[0].tag);
        end
      end
      if (in_ready) begin
        p      = ref_mul(in_a, in_b, in_signed, 24);
        e.prod = p[47:0];
        e.tag  = tag_ctr;
        sb_q.push_back(e);
        sent++;
        tag_ctr++;
      end
      k++;
    end
    iters = k;
    @(negedge clk);
    in_valid  = 1'b0;
    out_ready = 1'b1;
  endtask

  task automatic sweep8();
    logic [7:0]  bsel [8];
    logic [63:0] p;
    int          ka, kb, idx;
    bsel = '{8'h00, 8'h01, 8'h02, 8'h7F, 8'h80, 8'h81, 8'hFE, 8'hFF};
    for (int m = 0; m < N8 + 8; m++) begin
      @(negedge clk);
      #1;
      ka = m - 6;
      kb = m - 3;
      if (ka >= 0 && ka < N8) begin
        chk("w8_l1_valid", {63'b0, vld8_a}, 64'd1);
        chk("w8_l1_product", p8_a, exp8[ka]);
        chk("w8_l1_tag", t8_a, ka[3:0]);
      end else begin
        chk("w8_l1_valid", {63'b0, vld8_a}, 64'd0);
      end
      if (kb >= 0 && kb < N8) begin
        chk("w8_l4_valid", {63'b0, vld8_b}, 64'd1);
        chk("w8_l4_product", p8_b, exp8[kb]);
        chk("w8_l4_tag", t8_b, kb[3:0]);
      end else begin
        chk("w8_l4_valid", {63'b0, vld8_b}, 64'd0);
      end
      if (m == 0) begin
        chk("w8_l1_in_ready", {63'b0, rdy8_a}, 64'd1);
        chk("w8_l4_in_ready", {63'b0, rdy8_b}, 64'd1);
      end
      if (m < N8) begin
        idx     = m % 2048;
        s8      = (m >= 2048);
        a8      = idx[7:0];
        b8      = bsel[idx >> 8];
        tag8    = m[3:0];
        v8      = 1'b1;
        p       = ref_mul({56'b0, a8}, {56'b0, b8}, s8, 8);
        exp8[m] = p[15:0];
      end else begin
        v8 = 1'b0;
      end
    end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int base, iters;
    rst = 1'b1;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_signed = 1'b0; in_tag = '0;
    out_ready = 1'b1;
    v8 = 1'b0; a8 = '0; b8 = '0; s8 = 1'b0; tag8 = '0; ordy8 = 1'b1;

    repeat (2) @(posedge clk);
    #1;
    chk("reset_out_valid", {63'b0, out_valid}, 64'd0);
    chk("reset_out_product", out_product, 64'd0);
    chk("reset_out_tag", out_tag, 64'd0);
    chk("reset_w8_valid", {62'b0, vld8_a, vld8_b}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_in_ready", {63'b0, in_ready}, 64'd1);

    send_dir(24'hFFFFFF, 24'hFFFFFF, 1'b0, 4'h1, 48'hFFFFFE000001, "u_max_max");
    send_dir(24'hFFFFFF, 24'hFFFFFF, 1'b1, 4'h2, 48'h000000000001, "s_m1_m1");
    send_dir(24'h800000, 24'h800000, 1'b1, 4'h3, 48'h400000000000, "s_min_min");
    send_dir(24'hFFFFFF, 24'h000001, 1'b1, 4'h4, 48'hFFFFFFFFFFFF, "s_m1_p1");
    send_dir(24'h800000, 24'h800000, 1'b0, 4'h5, 48'h400000000000, "u_half_half");
    send_dir(24'h7FFFFF, 24'h800000, 1'b1, 4'h6, 48'hC00000800000, "s_max_min");
    send_dir(24'h000000, 24'hABCDEF, 1'b1, 4'h7, 48'h000000000000, "s_zero");

    base = n_out;
    stream(100, -1, 0, iters);
    chk("tput_accept_cycles", iters, 100);
    drain("tput_drain");
    chk("tput_count", n_out - base, 100);
    if (n_out - base >= 100) chk("tput_span", out_cyc[base+99] - out_cyc[base], 99);

    base = n_out;
    stream(30, 12, 5, iters);
    drain("stall_drain");
    chk("stall_count", n_out - base, 30);

    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      in_valid  = 1'b1;
      in_a      = 24'h123456 + 24'(i);
      in_b      = 24'h654321;
      in_signed = i[0];
      in_tag    = 4'hA;
      @(negedge clk);
    end
    rst      = 1'b1;
    in_tag   = 4'hB;
    @(posedge clk);
    #1;
    chk("rst_mid_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_mid_out_product", out_product, 64'd0);
    chk("rst_mid_out_tag", out_tag, 64'd0);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("rst_mid_in_ready", {63'b0, in_ready}, 64'd1);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      #1;
      chk("rst_no_stale", {63'b0, out_valid}, 64'd0);
    end

    send_dir(24'h000003, 24'h000005, 1'b0, 4'hC, 48'h00000000000F, "post_rst");

    sweep8();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mul_csa_pipe.md
Name: mul_csa_pipe

Overview:
- Parametrised, fully pipelined WIDTH x WIDTH integer multiplier.
- Datapath: AND/Baugh-Wooley partial-product generation, then a 3:2 carry-save reduction tree, then a final carry-propagate add.
- Adds per-operation signed/unsigned mode, valid/ready handshake with global stall, a pass-through tag and a configurable register spacing in the tree.
- Sits in the arithmetic unit as the shared integer/mantissa multiplier; one result per cycle when not stalled.

Parameters:
- WIDTH, 24: operand width; product is 2*WIDTH bits; legal range 4..64.
- LEVELS_PER_STAGE, 2: CSA levels between pipeline registers; legal range 1..NUM_LEVELS.
- TAG_W, 4: width of the user tag carried alongside each operation.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset, synchronous, active-high.
- in_valid  in  1  operands present.
- in_ready  out  1  block accepts operands this cycle.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier.
- in_signed  in  1  1 = both operands two's complement; 0 = both unsigned.
- in_tag  in  TAG_W  user tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- out_product  out  2*WIDTH  product, exact; no truncation or overflow.
- out_tag  out  TAG_W  tag of the operation in out_product.

Behaviour:
- NUM_LEVELS: number of 3:2 levels needed to reduce WIDTH rows (plus 1 correction row when signed logic is present) to 2 rows, repeatedly applying n -> 2*floor(n/3) + (n mod 3).
  - WIDTH=24 gives 25 rows -> 17 -> 12 -> 8 -> 6 -> 4 -> 3 -> 2, so NUM_LEVELS = 7.
- Stage 0: input register capturing in_a, in_b, in_signed, in_tag and valid.
- Stages 1..S: S = ceil(NUM_LEVELS / LEVELS_PER_STAGE).
  - Stage 1 holds partial-product generation plus the first LEVELS_PER_STAGE levels.
  - Each stage ends in a register.
  - Rows not consumed in a level pass through to the next level unchanged, registered at stage boundaries.
- Final stage: 2*WIDTH-bit carry-propagate add of the two rows, registered into out_product.
- LATENCY = S + 2 cycles from an accepted input to out_valid, absent stalls; default LATENCY = 6.
- Signed mode uses modified Baugh-Wooley:
  - invert the MSB-row and MSB-column cross terms;
  - add constant 1 at bit WIDTH and at bit 2*WIDTH-1.
  - Unsigned mode forces all inversions and constants to 0.
  - Mode travels with its operation, so mixed signed/unsigned back-to-back is legal.
- CSA row widths are 2*WIDTH; carry bit 0 = 0; carry out of bit 2*WIDTH-1 is discarded (it is mathematically zero after the final add).
- Flow control:
  - en = out_ready | ~out_valid; in_ready = en.
  - When en = 0, every pipeline register, valid bit and tag holds.
  - When en = 1, all stages advance by one.
  - Input is accepted when in_valid & in_ready; otherwise a bubble (valid=0) enters.
  - No bubble collapsing: internal bubbles occupy slots.
- out_product and out_tag hold stable while out_valid & ~out_ready.
- Reset:
  - all valid bits 0, out_product 0, out_tag 0;
  - in_ready = 1 in the cycle after reset is released;
  - in-flight operations are discarded; data registers other than outputs need no reset.
- Simultaneous rst and in_valid: reset wins; the operation is dropped.

Decomposition:
- Package mul_pkg: function computing NUM_LEVELS(rows), function ceil_div, localparams PROD_W = 2*WIDTH and LATENCY.
- Sub-module csa_row: one N-bit 3:2 compressor row (inputs a, b, c; outputs sum and carry shifted left by 1), instantiated by generate per level.
- Final adder: a behavioural '+' in the last stage.

Test Plan:
- Unsigned, WIDTH=24: a=0xFFFFFF, b=0xFFFFFF -> out_product=0xFFFFFE000001, out_valid exactly 6 cycles after acceptance.
- Signed: a=0xFFFFFF(-1), b=0xFFFFFF(-1) -> 0x000000000001; a=0x800000, b=0x800000 -> 0x400000000000; a=0xFFFFFF, b=0x000001 -> 0xFFFFFFFFFFFF.
- Throughput: 100 back-to-back random ops with alternating in_signed and incrementing tags -> results in order, tags match, one result per cycle, values match a reference model.
- Stall: hold out_ready=0 for 5 cycles mid-stream -> in_ready=0, out_product/out_tag stable, no loss or duplication after release.
- Reset mid-operation: assert rst with 3 ops in flight -> out_valid=0 and out_product=0 the next cycle; no stale result ever appears.
- Parameter sweep: WIDTH=8 with LEVELS_PER_STAGE=1 and with LEVELS_PER_STAGE=NUM_LEVELS -> exhaustive 65536 unsigned and signed products correct; LATENCY matches formula.
